// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants (RX and TX sides)
package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK_WAIT
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - N-flop synchroniser for an asynchronous single-bit input
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, loads RESET_VAL into every stage
//   d    asynchronous input
//   q    synchronised output (STAGES clk of latency)
module uart_rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: 8N1 by default, 8E1/8O1 with UART_RX_PARITY_EN
//
// Configuration macro: UART_RX_PARITY_EN (adds the parity bit and a live parity_err).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   RX_in        serial line, idle high, asynchronous to clk
//   RX_data_out  last received byte (LSB first on the line), held until next data_ready
//   data_ready   one-cycle strobe: frame complete
//   parity_err   one-cycle strobe with data_ready: parity mismatch
//   stop_err     one-cycle strobe with data_ready: stop bit sampled low
//   rx_busy      high from start-bit detection until return to idle
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX_in,
    output logic [UART_DATA_W-1:0] RX_data_out,
    output logic                   data_ready,
    output logic                   parity_err,
    output logic                   stop_err,
    output logic                   rx_busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_core: CLKS_PER_BIT must be even and >= 4, PARITY_ODD must be 0 or 1");
    end

    rx_state_e              state;
    rx_state_e              state_next;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shift;
    logic                   rx_s;
    logic                   mid_tick;
    logic                   frame_done;
    logic                   stop_ok;

    uart_rx_sync #(
        .STAGES    (2),
        .RESET_VAL (UART_IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (RX_in),
        .q   (rx_s)
    );

    // The start bit is checked half a bit in; every later sample lands a full
    // bit after the previous one, i.e. at the middle of each bit.
    assign mid_tick   = (state == RX_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);
    assign frame_done = (state == RX_STOP) && mid_tick;
    assign stop_ok    = (rx_s == UART_IDLE_LVL);
    assign rx_busy    = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (rx_s != UART_IDLE_LVL) state_next = RX_START;
            end
            RX_START: begin
                if (mid_tick) state_next = stop_ok ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (mid_tick && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_next = RX_PARITY;
`else
                    state_next = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (mid_tick) state_next = RX_STOP;
            end
`endif
            RX_STOP: begin
                // A low stop bit usually means a break; park until the line recovers.
                if (mid_tick) state_next = stop_ok ? RX_IDLE : RX_BREAK_WAIT;
            end
            RX_BREAK_WAIT: begin
                if (stop_ok) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            RX_data_out <= '0;
            data_ready  <= 1'b0;
            stop_err    <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            stop_err   <= 1'b0;

            if (state == RX_IDLE || state == RX_BREAK_WAIT || mid_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == RX_IDLE) begin
                bit_cnt <= '0;
            end else if (state == RX_DATA && mid_tick) begin
                shift   <= {rx_s, shift[UART_DATA_W-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (frame_done) begin
                RX_data_out <= shift;
                data_ready  <= 1'b1;
                stop_err    <= ~stop_ok;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_bad;
    logic parity_err_q;

    assign par_bad    = ((^{shift, par_bit}) != PARITY_ODD[0]);
    assign parity_err = parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            if (state == RX_PARITY && mid_tick) par_bit <= rx_s;
            // A stop error masks parity so the two strobes are never both high.
            if (frame_done) parity_err_q <= stop_ok & par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = 10 + PB;
    localparam int LAT   = (FRAME - 1) * CPB + CPB / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX_in = 1'b1;
    logic [7:0] RX_data_out;
    logic       data_ready;
    logic       parity_err;
    logic       stop_err;
    logic       rx_busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int         n_strobes = 0;
    logic [7:0] rec_data [32];
    logic       rec_perr [32];
    logic       rec_serr [32];
    int         rec_cyc  [32];
    int         unstable_cnt = 0;
    int         both_err_cnt = 0;
    int         orphan_cnt   = 0;
    int         hold_left    = 0;
    logic [7:0] hold_val     = 8'h00;

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_in       (RX_in),
        .RX_data_out (RX_data_out),
        .data_ready  (data_ready),
        .parity_err  (parity_err),
        .stop_err    (stop_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (hold_left > 0) begin
            if (RX_data_out !== hold_val) unstable_cnt++;
            hold_left--;
        end
        if (parity_err === 1'b1 && stop_err === 1'b1) both_err_cnt++;
        if (data_ready !== 1'b1 && (parity_err === 1'b1 || stop_err === 1'b1)) orphan_cnt++;
        if (data_ready === 1'b1) begin
            if (n_strobes < 32) begin
                rec_data[n_strobes] = RX_data_out;
                rec_perr[n_strobes] = parity_err;
                rec_serr[n_strobes] = stop_err;
                rec_cyc[n_strobes]  = cyc;
            end
            n_strobes++;
            hold_left = 2;
            hold_val  = RX_data_out;
        end
    end

    task automatic send_bit(input logic v);
        RX_in = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PB == 1) send_bit(p);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        RX_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        RX_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
        n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        n_cmp++; if (stop_err !== 1'b0) begin n_fail++; $display("FAIL reset_stop_err: got %b want 0", stop_err); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
        n_cmp++; if (RX_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", RX_data_out); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_good_frame;
        int n0;
        int c0;
        n0 = n_strobes;
        c0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(2 * CPB);
        n_cmp++; if (n_strobes !== n0 + 1) begin n_fail++; $display("FAIL good_count: got %0d want %0d", n_strobes - n0, 1); end
        if (n_strobes > n0) begin
            n_cmp++; if (rec_data[n0] !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %h want a5", rec_data[n0]); end
            n_cmp++; if (rec_perr[n0] !== 1'b0) begin n_fail++; $display("FAIL good_perr: got %b want 0", rec_perr[n0]); end
            n_cmp++; if (rec_serr[n0] !== 1'b0) begin n_fail++; $display("FAIL good_serr: got %b want 0", rec_serr[n0]); end
            n_cmp++; if (rec_cyc[n0] - c0 !== LAT) begin n_fail++; $display("FAIL good_latency: got %0d want %0d", rec_cyc[n0] - c0, LAT); end
        end
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_after: got %b want 0", rx_busy); end
    endtask

    task automatic test_parity_error;
        int n0;
        n0 = n_strobes;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(2 * CPB);
        n_cmp++; if (n_strobes !== n0 + 1) begin n_fail++; $display("FAIL par_count: got %0d want 1", n_strobes - n0); end
        if (n_strobes > n0) begin
            n_cmp++; if (rec_data[n0] !== 8'h3C) begin n_fail++; $display("FAIL par_data: got %h want 3c", rec_data[n0]); end
            n_cmp++; if (rec_perr[n0] !== 1'b1) begin n_fail++; $display("FAIL par_perr: got %b want 1", rec_perr[n0]); end
            n_cmp++; if (rec_serr[n0] !== 1'b0) begin n_fail++; $display("FAIL par_serr: got %b want 0", rec_serr[n0]); end
        end
    endtask

    task automatic test_stop_error;
        int n0;
        n0 = n_strobes;
        send_frame(8'h81, 1'b0, 1'b0);
        RX_in = 1'b0;
        repeat (40 - CPB) @(posedge clk);
        #1;
        n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_held: got %b want 1", rx_busy); end
        n_cmp++; if (n_strobes !== n0 + 1) begin n_fail++; $display("FAIL break_count_low: got %0d want 1", n_strobes - n0); end
        idle(2 * CPB);
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_release: got %b want 0", rx_busy); end
        n_cmp++; if (n_strobes !== n0 + 1) begin n_fail++; $display("FAIL break_count_end: got %0d want 1", n_strobes - n0); end
        if (n_strobes > n0) begin
            n_cmp++; if (rec_data[n0] !== 8'h81) begin n_fail++; $display("FAIL break_data: got %h want 81", rec_data[n0]); end
            n_cmp++; if (rec_serr[n0] !== 1'b1) begin n_fail++; $display("FAIL break_serr: got %b want 1", rec_serr[n0]); end
            n_cmp++; if (rec_perr[n0] !== 1'b0) begin n_fail++; $display("FAIL break_perr: got %b want 0", rec_perr[n0]); end
        end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = n_strobes;
        RX_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        RX_in = 1'b1;
        n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b want 1", rx_busy); end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_clear: got %b want 0", rx_busy); end
        idle(2 * CPB);
        n_cmp++; if (n_strobes !== n0) begin n_fail++; $display("FAIL glitch_no_strobe: got %0d want 0", n_strobes - n0); end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = n_strobes;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(2 * CPB);
        n_cmp++; if (n_strobes !== n0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", n_strobes - n0); end
        if (n_strobes > n0 + 1) begin
            n_cmp++; if (rec_data[n0] !== 8'h00) begin n_fail++; $display("FAIL b2b_data0: got %h want 00", rec_data[n0]); end
            n_cmp++; if (rec_data[n0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_data1: got %h want ff", rec_data[n0+1]); end
            n_cmp++; if (rec_cyc[n0+1] - rec_cyc[n0] !== FRAME * CPB) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", rec_cyc[n0+1] - rec_cyc[n0], FRAME * CPB); end
            n_cmp++; if ({rec_perr[n0], rec_serr[n0], rec_perr[n0+1], rec_serr[n0+1]} !== 4'b0000) begin
                n_fail++; $display("FAIL b2b_errors: got %b%b%b%b want 0000", rec_perr[n0], rec_serr[n0], rec_perr[n0+1], rec_serr[n0+1]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int         n0;
        logic [7:0] d;
        n0 = n_strobes;
        d  = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        RX_in = d[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", rx_busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        RX_in = 1'b1;
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_reset: got %b want 0", rx_busy); end
        n_cmp++; if (RX_data_out !== 8'h00) begin n_fail++; $display("FAIL abort_data_reset: got %h want 00", RX_data_out); end
        idle(3 * CPB);
        n_cmp++; if (n_strobes !== n0) begin n_fail++; $display("FAIL abort_no_strobe: got %0d want 0", n_strobes - n0); end
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(2 * CPB);
        n_cmp++; if (n_strobes !== n0 + 1) begin n_fail++; $display("FAIL abort_next_count: got %0d want 1", n_strobes - n0); end
        if (n_strobes > n0) begin
            n_cmp++; if (rec_data[n0] !== 8'h5A) begin n_fail++; $display("FAIL abort_next_data: got %h want 5a", rec_data[n0]); end
            n_cmp++; if ({rec_perr[n0], rec_serr[n0]} !== 2'b00) begin n_fail++; $display("FAIL abort_next_errors: got %b%b want 00", rec_perr[n0], rec_serr[n0]); end
        end
    endtask

    task automatic test_invariants;
        n_cmp++; if (both_err_cnt !== 0) begin n_fail++; $display("FAIL inv_both_errors: got %0d cycles want 0", both_err_cnt); end
        n_cmp++; if (unstable_cnt !== 0) begin n_fail++; $display("FAIL inv_data_hold: got %0d changes want 0", unstable_cnt); end
        n_cmp++; if (orphan_cnt !== 0) begin n_fail++; $display("FAIL inv_err_without_ready: got %0d cycles want 0", orphan_cnt); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        if (PB == 1) test_parity_error;
        test_stop_error;
        test_glitch;
        test_back_to_back;
        test_reset_abort;
        test_invariants;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
